// File: rtl/qupls4_uop_queue_ctrl.sv
// Head/tail, occupancy and lane-valid control for the Qupls4 micro-op queue.
// Optional statistics outputs (hwm_o, stall_cycles_o) are built when UOPQ_STATS_EN is defined.
module qupls4_uop_queue_ctrl #(
  parameter int MWIDTH  = 4,
  parameter int QDEPTH  = 32,
  parameter int ENQ_MAX = 12,
  parameter int PW      = $clog2(QDEPTH)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_i,
  input  logic                         stomp_i,
  input  logic                         enq_valid_i,
  input  logic [$clog2(ENQ_MAX+1)-1:0] enq_cnt_i,
  input  logic                         deq_ready_i,
  output logic                         rd_more_o,
  output logic [PW-1:0]                wr_ptr_o,
  output logic [PW-1:0]                rd_ptr_o,
  output logic [MWIDTH-1:0]            deq_mask_o,
  output logic [PW:0]                  count_o,
  output logic                         ovf_o
`ifdef UOPQ_STATS_EN
  ,
  output logic [PW:0]                  hwm_o,
  output logic [31:0]                  stall_cycles_o
`endif
);

  localparam int CW    = $clog2(ENQ_MAX + 1);
  localparam int CNT_W = PW + 1;
  localparam int DW    = $clog2(MWIDTH + 1);

  localparam logic [CW-1:0]    ENQ_MAX_C   = CW'(ENQ_MAX);
  localparam logic [CNT_W-1:0] RD_MORE_LIM = CNT_W'(QDEPTH - ENQ_MAX);

  function automatic logic [DW-1:0] popcount(input logic [MWIDTH-1:0] m);
    logic [DW-1:0] n;
    n = {DW{1'b0}};
    for (int i = 0; i < MWIDTH; i++) begin
      n = n + DW'(m[i]);
    end
    return n;
  endfunction

  // Lane i is valid when more than i micro-ops are resident.
  function automatic logic [MWIDTH-1:0] mask_of(input logic [CNT_W-1:0] c);
    logic [MWIDTH-1:0] m;
    m = {MWIDTH{1'b0}};
    for (int i = 0; i < MWIDTH; i++) begin
      m[i] = (c > CNT_W'(i));
    end
    return m;
  endfunction

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [MWIDTH-1:0] deq_mask_q, deq_mask_d;
  logic              rd_more_q, rd_more_d;
  logic              ovf_q, ovf_d;

  logic              enq_legal_s;
  logic              enq_fire_s;
  logic              enq_illegal_s;
  logic              deq_fire_s;
  logic [DW-1:0]     deq_n_s;
  logic [CW-1:0]     enq_n_s;

  // Handshake qualification for enqueue and dequeue.
  always_comb begin
    enq_legal_s   = (enq_cnt_i != {CW{1'b0}}) && (enq_cnt_i <= ENQ_MAX_C);
    enq_fire_s    = en_i & enq_valid_i & rd_more_q & ~stomp_i & enq_legal_s;
    enq_illegal_s = en_i & enq_valid_i & ~stomp_i &
                    (~rd_more_q | (enq_cnt_i > ENQ_MAX_C));
    deq_fire_s    = en_i & deq_ready_i & ~stomp_i & (count_q != {CNT_W{1'b0}});
    if (enq_fire_s) begin
      enq_n_s = enq_cnt_i;
    end else begin
      enq_n_s = {CW{1'b0}};
    end
    if (deq_fire_s) begin
      deq_n_s = popcount(deq_mask_q);
    end else begin
      deq_n_s = {DW{1'b0}};
    end
  end

  // Next-state for pointers, occupancy, lane mask and back-pressure.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    deq_mask_d = deq_mask_q;
    rd_more_d  = rd_more_q;
    ovf_d      = ovf_q | enq_illegal_s;
    if (!en_i) begin
      ovf_d = ovf_q;
    end else if (stomp_i) begin
      wr_ptr_d   = {PW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
      count_d    = {CNT_W{1'b0}};
      deq_mask_d = {MWIDTH{1'b0}};
      rd_more_d  = 1'b1;
    end else begin
      // Pointer arithmetic truncates to PW bits, giving the modulo-QDEPTH wrap.
      wr_ptr_d   = wr_ptr_q + PW'(enq_n_s);
      rd_ptr_d   = rd_ptr_q + PW'(deq_n_s);
      count_d    = count_q + CNT_W'(enq_n_s) - CNT_W'(deq_n_s);
      deq_mask_d = mask_of(count_d);
      rd_more_d  = (count_d <= RD_MORE_LIM);
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      deq_mask_q <= {MWIDTH{1'b0}};
      rd_more_q  <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      deq_mask_q <= deq_mask_d;
      rd_more_q  <= rd_more_d;
      ovf_q      <= ovf_d;
    end
  end

  assign wr_ptr_o   = wr_ptr_q;
  assign rd_ptr_o   = rd_ptr_q;
  assign count_o    = count_q;
  assign deq_mask_o = deq_mask_q;
  assign rd_more_o  = rd_more_q;
  assign ovf_o      = ovf_q;

`ifdef UOPQ_STATS_EN
  logic [CNT_W-1:0] hwm_q, hwm_d;
  logic [31:0]      stall_q, stall_d;

  // High-water mark survives stomp; stall counter saturates at all-ones.
  always_comb begin
    hwm_d   = hwm_q;
    stall_d = stall_q;
    if (en_i) begin
      if (count_d > hwm_q) begin
        hwm_d = count_d;
      end else begin
        hwm_d = hwm_q;
      end
      if (enq_valid_i && !rd_more_q && (stall_q != 32'hFFFF_FFFF)) begin
        stall_d = stall_q + 32'd1;
      end else begin
        stall_d = stall_q;
      end
    end else begin
      hwm_d   = hwm_q;
      stall_d = stall_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hwm_q   <= {CNT_W{1'b0}};
      stall_q <= 32'd0;
    end else begin
      hwm_q   <= hwm_d;
      stall_q <= stall_d;
    end
  end

  assign hwm_o          = hwm_q;
  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: doc/qupls4_uop_queue_ctrl.md
# qupls4_uop_queue_ctrl

Pointer/credit controller for the Qupls4 micro-op queue that sits between the micro-op translation stage and rename. It accepts a variable number of translated micro-ops per cycle, releases up to MWIDTH per cycle to rename under a ready handshake, and generates the `rd_more` back-pressure used to advance the extract stage. It also flushes on stomp and reports protocol violations. Storage stays in the queue datapath; this block owns only head/tail, occupancy and lane-valid control.

## Interface
- MWIDTH, 4: micro-ops released to rename per cycle (max)
- QDEPTH, 32: queue slots; power of two, ≥ 2×ENQ_MAX
- ENQ_MAX, 12: max micro-ops enqueued in one cycle
- PW, $clog2(QDEPTH): pointer width

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  pipeline enable; when low, all state holds
- stomp  in  1  flush queue (branch miss / exception)
- enq_valid  in  1  translation stage presents micro-ops
- enq_cnt  in  $clog2(ENQ_MAX+1)  micro-ops presented this cycle
- deq_ready  in  1  rename accepts a group this cycle
- rd_more  out  1  room for ENQ_MAX more micro-ops next cycle
- wr_ptr  out  PW  tail slot for first enqueued micro-op
- rd_ptr  out  PW  head slot for lane 0 of dequeue group
- deq_mask  out  MWIDTH  valid lanes of current dequeue group
- count  out  PW+1  current occupancy
- ovf  out  1  sticky: enqueue attempted while rd_more low, or enq_cnt>ENQ_MAX

## Operation
- Occupancy: `count` = micro-ops written and not yet released; range 0..QDEPTH.
- Enqueue fires when en & enq_valid & rd_more & !stomp & enq_cnt≠0 & enq_cnt≤ENQ_MAX: wr_ptr += enq_cnt (mod QDEPTH), count += enq_cnt.
- Illegal enqueue (enq_valid & en & !stomp with !rd_more or enq_cnt>ENQ_MAX): micro-ops dropped, pointers unchanged, ovf set; cleared only by reset.
- deq_mask lane i = (i < min(count, MWIDTH)); combinational from registered count.
- Dequeue fires when en & deq_ready & count≠0 & !stomp: rd_ptr += popcount(deq_mask), count -= same.
- Simultaneous enqueue and dequeue: count_next = count + enq − deq; both pointers advance same cycle.
- rd_more registered: rd_more_next = (count_next + ENQ_MAX ≤ QDEPTH). Because it is computed from count_next, it never permits an overflow.
- Stomp (with en): wr_ptr=rd_ptr=0, count=0, rd_more=1, deq_mask=0 next cycle. Stomp overrides same-cycle enqueue and dequeue. ovf is not touched.
- Pointer wrap: modulo QDEPTH. A group spanning slot QDEPTH−1→0 is legal; the datapath indexes (rd_ptr+i) mod QDEPTH.

## Timing
- Reset values: wr_ptr=0, rd_ptr=0, count=0, deq_mask=0, rd_more=1, ovf=0.
- Reset mid-operation clears state immediately (async) regardless of en.
- Enqueue→visible in deq_mask: 1 cycle (written cycle N, deliverable cycle N+1).
- rd_more reflects state after the current edge. The upstream stage samples it in the same cycle it drives enq_valid.
- Full: count=QDEPTH ⇒ rd_more=0. A dequeue still proceeds.
- Empty: count=0 ⇒ deq_mask=0. deq_ready is ignored.
- en low: nothing changes, including ovf detection.

## Configuration
- UOPQ_STATS_EN defined: adds outputs hwm (PW+1 bits, max count since reset/stomp-independent) and stall_cycles (32 bits, saturating, increments each en cycle with enq_valid & !rd_more). Both are reset to 0.
- UOPQ_STATS_EN undefined: these ports and their logic are absent. Functional behaviour is otherwise identical.

## Test plan
- Reset then enq_cnt=5 for one cycle, deq_ready=0 → count=5, wr_ptr=5, deq_mask=4'b1111, rd_more=1 (5+12≤32).
- From count=5 with deq_ready=1 for 2 cycles, no enqueue → count 1 then 0; rd_ptr=4 then 5; deq_mask 4'b0001 then 4'b0000.
- Fill with enq_cnt=12,8 (count=20), deq_ready=0 → rd_more=1 at 20, enqueue 1 more → count=21, rd_more=0; enq_valid again → dropped, ovf=1, count=21.
- Wrap: preload rd_ptr=wr_ptr=30, enqueue 6, dequeue 4 → rd_ptr=2, wr_ptr=4, count=2.
- Simultaneous enq_cnt=3, deq of 4 with count=4, plus stomp in the same cycle → next cycle count=0, pointers 0, rd_more=1, deq_mask=0.
- With UOPQ_STATS_EN: repeat the overflow scenario → hwm=21, stall_cycles=1. Async reset pulse mid-run → all outputs return to their reset values before the next edge.
